// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared constants, state encoding and mode helpers for the lift coefficient server
package lift_pkg;

   localparam int COEFF_W     = 30;
   localparam int ADDR_W      = 3;
   localparam int CNT_W       = ADDR_W + 1;
   localparam int DEPTH       = 1 << ADDR_W;
   localparam int N_IN_SMALL  = 6;
   localparam int N_IN_BIG    = 7;
   localparam int N_OUT_SMALL = 7;
   localparam int N_OUT_BIG   = 6;

   localparam logic MODE_SMALL = 1'b0;
   localparam logic MODE_BIG   = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   function automatic logic [CNT_W-1:0] n_in_of(input logic mode);
      return (mode == MODE_BIG) ? CNT_W'(N_IN_BIG) : CNT_W'(N_IN_SMALL);
   endfunction

   function automatic logic [CNT_W-1:0] n_out_of(input logic mode);
      return (mode == MODE_BIG) ? CNT_W'(N_OUT_BIG) : CNT_W'(N_OUT_SMALL);
   endfunction

   // One bit per result address that must be written before the set is complete.
   function automatic logic [DEPTH-1:0] full_mask(input logic [CNT_W-1:0] n);
      return DEPTH'((1 << n) - 1);
   endfunction

endpackage

// File: rtl/lift_coeff_bank.sv
// rtl/lift_coeff_bank.sv - register file with one write port and one registered read port
module lift_coeff_bank
   import lift_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [COEFF_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   input  logic               rzero,
   output logic [COEFF_W-1:0] rdata
);

   logic [COEFF_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Write-first forwarding so a same-cycle write is never missed by the read register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (rzero) begin
         rdata <= '0;
      end else if (we && (waddr == raddr)) begin
         rdata <= wdata;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/lift_coeff_server.sv
// rtl/lift_coeff_server.sv - loads coefficients, serves lift reads, collects results and drains them in order
module lift_coeff_server
   import lift_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mode_in,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COEFF_W-1:0] in_data,
   output logic               lift_mode,
   output logic               lift_start,
   input  logic [ADDR_W-1:0]  lift_rd_addr,
   output logic [COEFF_W-1:0] lift_coeff,
   input  logic [COEFF_W-1:0] lift_res,
   input  logic [ADDR_W-1:0]  lift_res_addr,
   input  logic               lift_res_we,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COEFF_W-1:0] out_data,
   output logic               out_last,
   output logic               busy,
   output logic               err
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   idx;
   logic [DEPTH-1:0]   mask;
   logic [CNT_W-1:0]   n_in;
   logic [CNT_W-1:0]   n_out;
   logic               accept;
   logic               res_in_range;
   logic               res_ok;
   logic               res_bad;
   logic               mask_full;
   logic               last_beat;
   logic               advance;
   logic               rd_zero;
   logic [ADDR_W-1:0]  out_raddr;

   assign n_in         = n_in_of(lift_mode);
   assign n_out        = n_out_of(lift_mode);
   assign accept       = in_valid & in_ready;
   assign res_in_range = ({1'b0, lift_res_addr} < n_out);
   assign res_ok       = (state == RUN) & lift_res_we & res_in_range;
   assign res_bad      = (state == RUN) & lift_res_we & ~res_in_range;
   assign mask_full    = (mask == full_mask(n_out));
   assign last_beat    = (state == DRAIN) & out_ready & (idx == n_out - 1'b1);
   assign advance      = (state == DRAIN) & out_ready & ~last_beat;
   assign rd_zero      = ({1'b0, lift_rd_addr} >= n_in);

   // Result bank is addressed with the index of the next cycle so out_data is ready with out_valid.
   assign out_raddr    = idx[ADDR_W-1:0] + ADDR_W'(advance);

   lift_coeff_bank u_bank_in (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (accept),
      .waddr (cnt[ADDR_W-1:0]),
      .wdata (in_data),
      .raddr (lift_rd_addr),
      .rzero (rd_zero),
      .rdata (lift_coeff)
   );

   lift_coeff_bank u_bank_out (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (res_ok),
      .waddr (lift_res_addr),
      .wdata (lift_res),
      .raddr (out_raddr),
      .rzero (1'b0),
      .rdata (out_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         mask       <= '0;
         lift_mode  <= MODE_SMALL;
         err        <= 1'b0;
         in_ready   <= 1'b0;
         lift_start <= 1'b0;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (accept) begin
                  lift_mode <= mode_in;
                  err       <= 1'b0;
                  cnt       <= CNT_W'(1);
                  busy      <= 1'b1;
                  if (n_in_of(mode_in) == CNT_W'(1)) begin
                     state      <= RUN;
                     in_ready   <= 1'b0;
                     lift_start <= 1'b1;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  cnt <= cnt + 1'b1;
                  if ((cnt + 1'b1) == n_in) begin
                     state      <= RUN;
                     in_ready   <= 1'b0;
                     lift_start <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (res_ok) begin
                  mask[lift_res_addr] <= 1'b1;
               end
               if (res_bad) begin
                  err <= 1'b1;
               end
               if (mask_full) begin
                  state      <= DRAIN;
                  lift_start <= 1'b0;
                  out_valid  <= 1'b1;
                  out_last   <= (n_out == CNT_W'(1));
                  idx        <= '0;
               end
            end
            DRAIN: begin
               if (last_beat) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  mask      <= '0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  idx       <= '0;
                  cnt       <= '0;
               end else if (advance) begin
                  idx      <= idx + 1'b1;
                  out_last <= ((idx + 2'd2) == n_out);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lift_coeff_server.sv
// tb/tb_lift_coeff_server.sv - randomized self-checking bench for lift_coeff_server
module tb_lift_coeff_server;
   import lift_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               mode_in = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [COEFF_W-1:0] in_data = '0;
   logic               lift_mode;
   logic               lift_start;
   logic [ADDR_W-1:0]  lift_rd_addr = '0;
   logic [COEFF_W-1:0] lift_coeff;
   logic [COEFF_W-1:0] lift_res = '0;
   logic [ADDR_W-1:0]  lift_res_addr = '0;
   logic               lift_res_we = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [COEFF_W-1:0] out_data;
   logic               out_last;
   logic               busy;
   logic               err;

   always #5 clk = ~clk;

   lift_coeff_server dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mode_in       (mode_in),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .lift_mode     (lift_mode),
      .lift_start    (lift_start),
      .lift_rd_addr  (lift_rd_addr),
      .lift_coeff    (lift_coeff),
      .lift_res      (lift_res),
      .lift_res_addr (lift_res_addr),
      .lift_res_we   (lift_res_we),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .busy          (busy),
      .err           (err)
   );

   int                 checks = 0;
   int                 failures = 0;
   logic [COEFF_W-1:0] vals [8];
   logic [COEFF_W-1:0] exp_res [8];
   bit                 written [8];
   bit                 exp_err = 1'b0;
   logic               cur_mode = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
      end
   endtask

   function automatic int nin(input logic m);
      return m ? N_IN_BIG : N_IN_SMALL;
   endfunction

   function automatic int nout(input logic m);
      return m ? N_OUT_BIG : N_OUT_SMALL;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic m, input bit gaps);
      int acc = 0;
      int guard = 0;
      bit hs;
      cur_mode = m;
      for (int i = 0; i < 8; i++) written[i] = 1'b0;
      check("load_idle_ready", in_ready, 1);
      while (acc < nin(m) && guard < 200) begin
         in_valid = gaps ? ($urandom_range(3, 0) != 0) : 1'b1;
         mode_in  = (acc == 0) ? m : ~m;
         in_data  = vals[acc];
         hs       = in_valid && in_ready;
         check("load_no_start", lift_start, 0);
         tick;
         guard++;
         if (hs) begin
            acc++;
            if (acc == 1) begin
               exp_err = 1'b0;
               check("load_err_clear", err, 0);
            end
         end
      end
      in_valid = 1'b0;
      if (acc < nin(m)) check("load_timeout", acc, nin(m));
      check("load_start", lift_start, 1);
      check("load_ready_low", in_ready, 0);
      check("load_busy", busy, 1);
      check("load_mode", lift_mode, m);
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a);
      logic [31:0] e;
      e = (int'(a) < nin(cur_mode)) ? 32'(vals[a]) : 32'd0;
      lift_rd_addr = a;
      in_valid     = 1'b1;
      in_data      = COEFF_W'($urandom);
      tick;
      check("rd_coeff", lift_coeff, e);
      in_valid = 1'b0;
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [COEFF_W-1:0] v);
      check("run_start_held", lift_start, 1);
      lift_res_we   = 1'b1;
      lift_res_addr = a;
      lift_res      = v;
      tick;
      lift_res_we = 1'b0;
      if (int'(a) < nout(cur_mode)) begin
         exp_res[a] = v;
         written[a] = 1'b1;
      end else begin
         exp_err = 1'b1;
      end
   endtask

   task automatic finish_run;
      check("run_full_start", lift_start, 1);
      check("run_err", err, exp_err);
      tick;
      check("run_exit_start", lift_start, 0);
      check("run_exit_valid", out_valid, 1);
   endtask

   task automatic do_results(input bit with_err);
      int n;
      logic [ADDR_W-1:0] perm [8];
      logic [ADDR_W-1:0] t;
      int j;
      n = nout(cur_mode);
      for (int i = 0; i < 8; i++) perm[i] = ADDR_W'(i);
      for (int i = n - 1; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(3, 0) == 0) begin
            if (with_err && $urandom_range(1, 0) == 1)
               do_write(ADDR_W'($urandom_range(7, n)), COEFF_W'($urandom));
            else if (k > 0)
               do_write(perm[$urandom_range(k - 1, 0)], COEFF_W'($urandom));
         end
         do_write(perm[k], COEFF_W'($urandom));
      end
      finish_run;
   endtask

   task automatic do_drain(input int style);
      int k = 0;
      int cyc = 0;
      int n;
      bit rdy;
      n = nout(cur_mode);
      while (k < n && cyc < 200) begin
         case (style)
            0: rdy = 1'b1;
            1: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: rdy = ($urandom_range(1, 0) == 1);
         endcase
         out_ready = rdy;
         check("drain_valid", out_valid, 1);
         check("drain_data", out_data, exp_res[k]);
         check("drain_last", out_last, (k == n - 1));
         tick;
         cyc++;
         if (rdy) k++;
      end
      out_ready = 1'b0;
      if (k < n) check("drain_timeout", k, n);
      check("drain_end_valid", out_valid, 0);
      check("drain_end_busy", busy, 0);
      check("drain_end_ready", in_ready, 1);
      check("drain_end_err", err, exp_err);
   endtask

   initial begin
      int d1 [7] = '{671786186, 371403231, 941041075, 757388970, 763397601, 388890965, 662959639};
      int d0 [6] = '{370922924, 422943464, 164547197, 814660070, 705611185, 887303870};

      rst_n = 1'b0;
      tick;
      tick;
      check("rst_in_ready", in_ready, 0);
      check("rst_start", lift_start, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_err", err, 0);
      check("rst_coeff", lift_coeff, 0);
      check("rst_out_data", out_data, 0);
      check("rst_mode", lift_mode, 0);
      rst_n = 1'b1;
      tick;
      check("idle_ready", in_ready, 1);
      check("idle_busy", busy, 0);

      lift_res_we = 1'b1;
      lift_res_addr = 3'd7;
      tick;
      lift_res_we = 1'b0;
      tick;
      check("idle_we_err", err, 0);
      check("idle_we_busy", busy, 0);

      for (int i = 0; i < 7; i++) vals[i] = COEFF_W'(d1[i]);
      do_load(MODE_BIG, 1'b0);
      do_read(3'd6);
      do_read(3'd0);
      do_read(3'd7);
      do_write(3'd5, 30'd105);
      do_write(3'd0, 30'd100);
      do_write(3'd3, 30'd103);
      do_write(3'd6, 30'd77);
      do_write(3'd3, 30'd999);
      do_write(3'd1, 30'd101);
      do_write(3'd4, 30'd104);
      do_write(3'd2, 30'd102);
      finish_run;
      check("dir_err_set", err, 1);
      do_drain(1);

      for (int i = 0; i < 6; i++) vals[i] = COEFF_W'(d0[i]);
      vals[6] = COEFF_W'($urandom);
      do_load(MODE_SMALL, 1'b1);
      do_read(3'd3);
      do_read(3'd6);
      do_results(1'b0);
      do_drain(2);

      for (int i = 0; i < 7; i++) vals[i] = COEFF_W'($urandom);
      do_load(MODE_BIG, 1'b1);
      do_write(3'd1, 30'd11);
      do_write(3'd4, 30'd44);
      do_write(3'd0, 30'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_start", lift_start, 0);
      check("midrst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_err = 1'b0;
      tick;
      check("midrst_ready", in_ready, 1);
      check("midrst_valid", out_valid, 0);
      check("midrst_err", err, 0);
      for (int i = 0; i < 7; i++) vals[i] = COEFF_W'($urandom);
      do_load(MODE_SMALL, 1'b0);
      do_read(3'd5);
      do_results(1'b1);
      do_drain(0);

      for (int it = 0; it < 12; it++) begin
         for (int i = 0; i < 7; i++) vals[i] = COEFF_W'($urandom);
         do_load(logic'($urandom_range(1, 0)), 1'b1);
         for (int r = 0; r < 3; r++) do_read(ADDR_W'($urandom_range(7, 0)));
         do_results(1'b1);
         do_drain(2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
